// File: rtl/vmul_arbiter.sv
// vmul_arbiter: shares one pipelined multiplier among four requesters.
// A winner is picked among the active requests, and its operands are latched
// into the registers that feed the multiplier. The block then waits out the
// multiplier latency and returns the product with a one-hot done pulse.
// Optional feature macro: VMUL_ARB_FIXED_PRIO_EN selects fixed priority
// (requester 0 highest) instead of the default round-robin.
module vmul_arbiter #(
  parameter int WIDTH = 16,
  parameter int LAT   = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           req,
  input  logic [4*WIDTH-1:0]   a_in,
  input  logic [4*WIDTH-1:0]   b_in,
  output logic [3:0]           gnt,
  output logic [1:0]           sel,
  output logic [WIDTH-1:0]     mul_a,
  output logic [WIDTH-1:0]     mul_b,
  output logic                 mul_go,
  input  logic [2*WIDTH-1:0]   mul_p,
  output logic [3:0]           done,
  output logic [2*WIDTH-1:0]   p_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t               state, state_nxt;
  logic [1:0]           ptr, ptr_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [1:0]           win;
  logic [1:0]           sel_nxt;
  logic [WIDTH-1:0]     mula_nxt, mulb_nxt;
  logic [2*WIDTH-1:0]   pout_nxt;
  logic [3:0]           gnt_nxt, done_nxt;
  logic                 go_nxt;
`ifndef VMUL_ARB_FIXED_PRIO_EN
  logic [1:0]           cand;
`endif

  // Pick the winner among the active requests; the last match in the scan holds the highest priority
  always_comb begin
    win = 2'd0;
`ifdef VMUL_ARB_FIXED_PRIO_EN
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) win = 2'(i);
    end
`else
    cand = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) win = cand;
    end
`endif
  end

  // Next-state and next-output logic. The counter is loaded with LAT when the
  // multiplier is started. Completion happens on the edge where it reads zero,
  // and this is the first edge at which mul_p is valid.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    sel_nxt   = sel;
    mula_nxt  = mul_a;
    mulb_nxt  = mul_b;
    pout_nxt  = p_out;
    gnt_nxt   = 4'b0000;
    done_nxt  = 4'b0000;
    go_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          sel_nxt   = win;
          mula_nxt  = a_in[win*WIDTH +: WIDTH];
          mulb_nxt  = b_in[win*WIDTH +: WIDTH];
          gnt_nxt   = 4'b0001 << win;
          go_nxt    = 1'b1;
`ifndef VMUL_ARB_FIXED_PRIO_EN
          ptr_nxt   = win;
`endif
          cnt_nxt   = 4'(LAT);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          pout_nxt  = mul_p;
          done_nxt  = 4'b0001 << sel;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset discards any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= 2'd3;
      cnt    <= 4'd0;
      sel    <= 2'd0;
      mul_a  <= '0;
      mul_b  <= '0;
      p_out  <= '0;
      gnt    <= 4'b0000;
      done   <= 4'b0000;
      mul_go <= 1'b0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      cnt    <= cnt_nxt;
      sel    <= sel_nxt;
      mul_a  <= mula_nxt;
      mul_b  <= mulb_nxt;
      p_out  <= pout_nxt;
      gnt    <= gnt_nxt;
      done   <= done_nxt;
      mul_go <= go_nxt;
    end
  end

endmodule

// File: tb/tb_vmul_arbiter.sv
// tb_vmul_arbiter: directed scenarios for vmul_arbiter. It uses a queue-based
// scoreboard and models the multiplier as a LAT-stage delayed a*b.
module tb_vmul_arbiter;
  localparam int WIDTH = 16;
  localparam int LAT   = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [3:0]           req = 4'b0000;
  logic [4*WIDTH-1:0]   a_in = '0;
  logic [4*WIDTH-1:0]   b_in = '0;
  logic [3:0]           gnt;
  logic [1:0]           sel;
  logic [WIDTH-1:0]     mul_a, mul_b;
  logic                 mul_go;
  logic [2*WIDTH-1:0]   mul_p;
  logic [3:0]           done;
  logic [2*WIDTH-1:0]   p_out;

  typedef struct {
    logic [1:0]       idx;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } gntExp_t;

  typedef struct {
    logic [1:0]         idx;
    logic [2*WIDTH-1:0] prod;
  } doneExp_t;

  gntExp_t  gntQ[$];
  doneExp_t doneQ[$];
  int       gntCycles[$];
  int       checks = 0;
  int       errors = 0;
  int       cycle = 0;
  int       gntCount = 0;
  int       doneCount = 0;
  int       lastGntCycle = 0;

  logic [2*WIDTH-1:0] pipeData [LAT];
  logic               pipeVld  [LAT];

  vmul_arbiter #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .a_in   (a_in),
    .b_in   (b_in),
    .gnt    (gnt),
    .sel    (sel),
    .mul_a  (mul_a),
    .mul_b  (mul_b),
    .mul_go (mul_go),
    .mul_p  (mul_p),
    .done   (done),
    .p_out  (p_out)
  );

  // Free-running clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  // Multiplier model: the product appears LAT cycles after mul_go and is garbage otherwise
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        pipeVld[i]  <= 1'b0;
        pipeData[i] <= '0;
      end
    end else begin
      pipeVld[0]  <= mul_go;
      pipeData[0] <= {16'h0000, mul_a} * {16'h0000, mul_b};
      for (int i = 1; i < LAT; i++) begin
        pipeVld[i]  <= pipeVld[i-1];
        pipeData[i] <= pipeData[i-1];
      end
    end
  end
  assign mul_p = pipeVld[LAT-1] ? pipeData[LAT-1] : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a grant or a completion
  always @(negedge clk) begin
    if (rst_n) begin
      if (gnt != 4'b0000 || mul_go) begin
        gntCount++;
        lastGntCycle = cycle;
        gntCycles.push_back(cycle);
        if (gntQ.size() == 0) begin
          checkOutput("unexpected_gnt", {60'd0, gnt}, 64'd0);
        end else begin
          automatic gntExp_t e = gntQ.pop_front();
          checkOutput("gnt",    {60'd0, gnt},   {60'd0, 4'b0001 << e.idx});
          checkOutput("mul_go", {63'd0, mul_go}, 64'd1);
          checkOutput("sel",    {62'd0, sel},   {62'd0, e.idx});
          checkOutput("mul_a",  {48'd0, mul_a}, {48'd0, e.a});
          checkOutput("mul_b",  {48'd0, mul_b}, {48'd0, e.b});
        end
      end
      if (done != 4'b0000) begin
        doneCount++;
        if (doneQ.size() == 0) begin
          checkOutput("unexpected_done", {60'd0, done}, 64'd0);
        end else begin
          automatic doneExp_t d = doneQ.pop_front();
          checkOutput("done",         {60'd0, done},  {60'd0, 4'b0001 << d.idx});
          checkOutput("p_out",        {32'd0, p_out}, {32'd0, d.prod});
          checkOutput("done_latency", 64'(cycle - lastGntCycle), 64'(LAT + 1));
          checkOutput("done_gnt_excl", {60'd0, gnt}, 64'd0);
        end
      end
    end
  end

  task automatic setOperands(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  task automatic expectOp(input logic [1:0] idx, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [2*WIDTH-1:0] prod);
    gntQ.push_back('{idx: idx, a: a, b: b});
    doneQ.push_back('{idx: idx, prod: prod});
  endtask

  task automatic applyStimulus(input logic [3:0] r);
    @(negedge clk);
    #1;
    req = r;
  endtask

  // Holds the request pattern until n completions arrive, then drops it before the next sample
  task automatic runOps(input logic [3:0] r, input int n);
    int target;
    int budget;
    target = doneCount + n;
    budget = 0;
    applyStimulus(r);
    while (doneCount < target && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    req = 4'b0000;
    checkOutput("ops_completed", 64'(doneCount), 64'(target));
    repeat (2) @(negedge clk);
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_gnt"},    {60'd0, gnt},    64'd0);
    checkOutput({tag, "_done"},   {60'd0, done},   64'd0);
    checkOutput({tag, "_mul_go"}, {63'd0, mul_go}, 64'd0);
    checkOutput({tag, "_sel"},    {62'd0, sel},    64'd0);
    checkOutput({tag, "_mul_a"},  {48'd0, mul_a},  64'd0);
    checkOutput({tag, "_mul_b"},  {48'd0, mul_b},  64'd0);
    checkOutput({tag, "_p_out"},  {32'd0, p_out},  64'd0);
  endtask

  initial begin
    int budget;
    int base;

    // Reset values
    #2;
    checkAllZero("reset");
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Single request
    $display("[TB] single request");
    setOperands(0, 16'h1234, 16'h0010);
    expectOp(2'd0, 16'h1234, 16'h0010, 32'h0001_2340);
    runOps(4'b0001, 1);

    // All requesters held, starting from reset so requester 0 leads
    $display("[TB] all requesters held");
    resetDut();
    setOperands(0, 16'h0003, 16'h0005);
    setOperands(1, 16'h0100, 16'h0100);
    setOperands(2, 16'hABCD, 16'h0002);
    setOperands(3, 16'hFFFF, 16'h0001);
    expectOp(2'd0, 16'h0003, 16'h0005, 32'h0000_000F);
    expectOp(2'd1, 16'h0100, 16'h0100, 32'h0001_0000);
    expectOp(2'd2, 16'hABCD, 16'h0002, 32'h0001_579A);
    expectOp(2'd3, 16'hFFFF, 16'h0001, 32'h0000_FFFF);
    expectOp(2'd0, 16'h0003, 16'h0005, 32'h0000_000F);
    gntCycles.delete();
    runOps(4'b1111, 5);
    checkOutput("held_gnt_count", 64'(gntCycles.size()), 64'd5);
    for (int i = 1; i < gntCycles.size(); i++)
      checkOutput("gnt_spacing", 64'(gntCycles[i] - gntCycles[i-1]), 64'(LAT + 2));

    // Round-robin wrap: after granting 2, requester 0 beats requester 2
    $display("[TB] round-robin wrap");
    setOperands(2, 16'h0007, 16'h0009);
    expectOp(2'd2, 16'h0007, 16'h0009, 32'h0000_003F);
    runOps(4'b0100, 1);
    setOperands(0, 16'h0011, 16'h0011);
    expectOp(2'd0, 16'h0011, 16'h0011, 32'h0000_0121);
    runOps(4'b0101, 1);

    // Boundary operands
    $display("[TB] boundary operands");
    setOperands(0, 16'h0000, 16'hFFFF);
    expectOp(2'd0, 16'h0000, 16'hFFFF, 32'h0000_0000);
    runOps(4'b0001, 1);
    setOperands(1, 16'hFFFF, 16'hFFFF);
    expectOp(2'd1, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001);
    runOps(4'b0010, 1);

    // Reset during BUSY: the grant is expected, the completion is not
    $display("[TB] reset during busy");
    setOperands(2, 16'h0002, 16'h0003);
    gntQ.push_back('{idx: 2'd2, a: 16'h0002, b: 16'h0003});
    base = gntCount;
    budget = 0;
    applyStimulus(4'b0100);
    while (gntCount == base && budget < 20) begin
      @(negedge clk);
      #1;
      budget++;
    end
    checkOutput("busy_gnt_seen", 64'(gntCount), 64'(base + 1));
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    checkAllZero("midreset");
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    base = doneCount;
    repeat (10) @(negedge clk);
    checkOutput("no_done_after_reset", 64'(doneCount), 64'(base));
    setOperands(3, 16'h0020, 16'h0030);
    expectOp(2'd3, 16'h0020, 16'h0030, 32'h0000_0600);
    runOps(4'b1000, 1);

    // Two requesters held from reset; fixed priority starves requester 1
    $display("[TB] two requesters held");
    resetDut();
    setOperands(0, 16'h0005, 16'h0006);
    setOperands(1, 16'h0007, 16'h0008);
`ifdef VMUL_ARB_FIXED_PRIO_EN
    expectOp(2'd0, 16'h0005, 16'h0006, 32'h0000_001E);
    expectOp(2'd0, 16'h0005, 16'h0006, 32'h0000_001E);
    expectOp(2'd0, 16'h0005, 16'h0006, 32'h0000_001E);
`else
    expectOp(2'd0, 16'h0005, 16'h0006, 32'h0000_001E);
    expectOp(2'd1, 16'h0007, 16'h0008, 32'h0000_0038);
    expectOp(2'd0, 16'h0005, 16'h0006, 32'h0000_001E);
`endif
    runOps(4'b0011, 3);

    // Every expected event must have been consumed
    repeat (4) @(negedge clk);
    checkOutput("gnt_queue_empty",  64'(gntQ.size()),  64'd0);
    checkOutput("done_queue_empty", 64'(doneQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
